// File: rtl/uart_pkt_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkt_pkg
// Shared definitions for the UART packet receiver: the packet FSM state
// encoding, header opcodes, error codes and a width helper.
// Build option: UART_PKT_CHECKSUM_EN adds the CHECK state used for the
// trailing checksum frame of write packets.
// -----------------------------------------------------------------------------
package uart_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
`ifdef UART_PKT_CHECKSUM_EN
        ST_CHECK   = 2'd2,
`endif
        ST_HOLD    = 2'd3
    } state_e;

    localparam logic [1:0] OP_WRITE = 2'b11;
    localparam logic [1:0] OP_READ  = 2'b01;

    localparam logic [1:0] ERR_BAD_OPCODE = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM   = 2'd2;
    localparam logic [1:0] ERR_OVERRUN    = 2'd3;

    // $clog2 that never yields zero, so counters of tiny ranges stay legal
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
// Deserialises one UART frame: start bit, DATA_BITS data bits LSB first,
// one stop bit. Each bit is sampled at its centre.
// Ports:
//   clk          in   clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   rx_i         in   serial line, idle high (asynchronous to clk)
//   frame_data_o out  last received frame, stable after frame_done_o
//   frame_done_o out  one-cycle pulse when a frame has been received
// -----------------------------------------------------------------------------
module uart_frame_rx
    import uart_pkt_pkg::*;
#(
    parameter int DATA_BITS    = 12,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] frame_data_o,
    output logic                 frame_done_o
);

    localparam int CNT_W = clog2_min1(CLKS_PER_BIT);
    localparam int BIT_W = clog2_min1(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]           sync_q;
    logic [1:0]           rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s = sync_q[1];

    // Start bit is re-checked at its centre so a glitch does not start a frame;
    // from then on every bit is sampled one full bit period later.
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    clk_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (clk_cnt_q == FULL_BIT) begin
                    done_d     = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
        end
    end

    assign frame_data_o = shift_q;
    assign frame_done_o = done_q;

endmodule

// File: rtl/uart_packet_rx.sv
// -----------------------------------------------------------------------------
// uart_packet_rx
// Assembles UART frames into read/write packets. A header frame carries the
// opcode, memory select and address; write packets are followed by
// BYTE_COUNT payload frames. The finished packet is held until accepted.
// Build option: UART_PKT_CHECKSUM_EN -- write packets carry one extra frame
// holding the XOR of all payload bytes, checked before the packet is offered.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   rx            UART serial input, idle high
//   pkt_valid/pkt_ready  packet handshake
//   pkt_data      payload, first byte in the MSBs (zero for reads)
//   pkt_addr, pkt_mem_type, pkt_rw  header fields (rw=1 for writes)
//   err_valid/err_code   one-cycle error pulse and its code
// -----------------------------------------------------------------------------
module uart_packet_rx
    import uart_pkt_pkg::*;
#(
    parameter int BYTE_COUNT     = 4,
    parameter int DATA_BITS      = 12,
    parameter int ADDR_W         = 9,
    parameter int CLKS_PER_BIT   = 868,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [8*BYTE_COUNT-1:0] pkt_data,
    output logic [ADDR_W-1:0]       pkt_addr,
    output logic                    pkt_mem_type,
    output logic                    pkt_rw,
    output logic                    err_valid,
    output logic [1:0]              err_code
);

    localparam int CNT_W = clog2_min1(BYTE_COUNT + 1);
    localparam int TMO_W = clog2_min1(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTE_COUNT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [DATA_BITS-1:0] frame_data;
    logic                 frame_done;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [8*BYTE_COUNT-1:0] data_q, data_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    mem_q, mem_d;
    logic                    rw_q, rw_d;
    logic                    err_valid_q, err_valid_d;
    logic [1:0]              err_code_q, err_code_d;
    logic                    take_header;
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    uart_frame_rx #(
        .DATA_BITS   (DATA_BITS),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_frame_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx),
        .frame_data_o(frame_data),
        .frame_done_o(frame_done)
    );

    // Packet FSM. A frame arriving in IDLE, or in HOLD in the very cycle the
    // held packet is accepted, is decoded as a header (take_header).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        data_d      = data_q;
        addr_d      = addr_q;
        mem_d       = mem_q;
        rw_d        = rw_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        take_header = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                take_header = frame_done;
            end
            ST_PAYLOAD: begin
                if (frame_done) begin
                    tmo_d = '0;
                    for (int i = 0; i < BYTE_COUNT; i++) begin
                        if (cnt_q == CNT_W'(BYTE_COUNT - 1 - i)) begin
                            data_d[i*8 +: 8] = frame_data[7:0];
                        end
                    end
`ifdef UART_PKT_CHECKSUM_EN
                    csum_d = csum_q ^ frame_data[7:0];
`endif
                    if (cnt_q == LAST_BYTE) begin
`ifdef UART_PKT_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_HOLD;
`endif
                    end
                    // Stops at BYTE_COUNT because the FSM leaves PAYLOAD there
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (tmo_q == TMO_LAST) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`ifdef UART_PKT_CHECKSUM_EN
            ST_CHECK: begin
                if (frame_done) begin
                    tmo_d = '0;
                    if (frame_data[7:0] == csum_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CHECKSUM;
                        state_d     = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`endif
            ST_HOLD: begin
                if (pkt_ready) begin
                    state_d     = ST_IDLE;
                    take_header = frame_done;
                end else if (frame_done) begin
                    // Frame is dropped; the held packet must not change
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_header) begin
            case (frame_data[DATA_BITS-1 -: 2])
                OP_WRITE: begin
                    addr_d  = frame_data[ADDR_W-1:0];
                    mem_d   = frame_data[ADDR_W];
                    rw_d    = 1'b1;
                    data_d  = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
`ifdef UART_PKT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = ST_PAYLOAD;
                end
                OP_READ: begin
                    addr_d  = frame_data[ADDR_W-1:0];
                    mem_d   = frame_data[ADDR_W];
                    rw_d    = 1'b0;
                    data_d  = '0;
                    state_d = ST_HOLD;
                end
                default: begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_BAD_OPCODE;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            mem_q       <= 1'b0;
            rw_q        <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            mem_q       <= mem_d;
            rw_q        <= rw_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign pkt_valid    = (state_q == ST_HOLD);
    assign pkt_data     = data_q;
    assign pkt_addr     = addr_q;
    assign pkt_mem_type = mem_q;
    assign pkt_rw       = rw_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;

endmodule

// File: doc/uart_packet_rx.md
UART_PACKET_RX -- requirements
Module: uart_packet_rx

Interface
REQ-001 SHALL have parameter BYTE_COUNT, default 4: payload bytes per write packet, legal 1..8.
REQ-002 SHALL have parameter DATA_BITS, default 12: bits per UART frame, legal 12..16.
REQ-003 SHALL have parameter ADDR_W, default 9: target address width, legal 1..DATA_BITS-3.
REQ-004 SHALL have parameter CLKS_PER_BIT, default 868: UART bit period in clk cycles, passed to the sub-module.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 200000: maximum clk cycles allowed between frames inside one packet.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 rx  in  1  UART serial input, idle high.
REQ-009 pkt_valid  out  1  packet held and available.
REQ-010 pkt_ready  in  1  consumer accepts packet.
REQ-011 pkt_data  out  8*BYTE_COUNT  payload, first byte received in MSBs.
REQ-012 pkt_addr  out  ADDR_W  target address.
REQ-013 pkt_mem_type  out  1  target memory select.
REQ-014 pkt_rw  out  1  1 = write packet, 0 = read packet.
REQ-015 err_valid  out  1  one-cycle error pulse.
REQ-016 err_code  out  2  0 bad opcode, 1 timeout, 2 checksum, 3 overrun; valid only with err_valid.

Function
REQ-017 States SHALL be IDLE, PAYLOAD, CHECK (only with the REQ-033 macro), and HOLD.
REQ-018 Header frame: bits[DATA_BITS-1:DATA_BITS-2] opcode; bit[ADDR_W] mem_type; bits[ADDR_W-1:0] addr; all other bits ignored.
REQ-019 IDLE, frame with opcode 2'b11: latch addr, mem_type, rw=1, clear byte counter, go to PAYLOAD.
REQ-020 IDLE, frame with opcode 2'b01: latch addr, mem_type, rw=0, pkt_data=0, go to HOLD.
REQ-021 IDLE, any other opcode: pulse err_valid with code 0 and stay in IDLE.
REQ-022 PAYLOAD: each frame's bits[7:0] SHALL be stored at byte lane BYTE_COUNT-1-count; after frame BYTE_COUNT, go to HOLD (or to CHECK).
REQ-023 pkt_valid SHALL rise the cycle after the completing frame's done pulse and stay high in HOLD; pkt_* SHALL stay stable while pkt_valid is high.
REQ-024 A cycle with pkt_valid && pkt_ready SHALL return to IDLE; pkt_valid is low on the next cycle.
REQ-025 HOLD, frame done without the REQ-024 handshake: discard the frame, pulse err code 3, keep the packet.
REQ-026 HOLD, frame done in the same cycle as the handshake: process the frame as an IDLE header.
REQ-027 Timeout counter SHALL clear on entry to PAYLOAD/CHECK and on every frame done.
REQ-028 Timeout counter reaching TIMEOUT_CYCLES-1 in PAYLOAD/CHECK: pulse err code 1 and go to IDLE; partial data is not presented.
REQ-029 Counter widths SHALL be $clog2-derived; the byte counter SHALL never wrap past BYTE_COUNT.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE and clear all counters.
REQ-031 On reset: pkt_valid=0, pkt_data=0, pkt_addr=0, pkt_mem_type=0, pkt_rw=0, err_valid=0, err_code=0.
REQ-032 Reset mid-packet SHALL discard the packet and reset the sub-module; reception restarts on the next start bit after release.

Configuration
REQ-033 Macro UART_PKT_CHECKSUM_EN defined: write packets SHALL carry one extra frame whose bits[7:0] equal the XOR of all payload bytes.
REQ-034 That frame SHALL be received in CHECK; match goes to HOLD, mismatch pulses err code 2 and goes to IDLE.
REQ-035 Macro undefined: no CHECK state, no checksum logic, and PAYLOAD goes directly to HOLD; read packets never carry a checksum.

Structure
REQ-036 Shared package uart_pkt_pkg SHALL hold the state enum, opcode constants OP_WRITE=2'b11 and OP_READ=2'b01, and the err_code constants.
REQ-037 Frame deserialisation SHALL live in sub-module uart_frame_rx (params DATA_BITS, CLKS_PER_BIT; outputs frame data and a one-cycle done pulse).

Verification
REQ-038 Write header 12'hC05, then bytes 11,22,33,44, pkt_ready=1 -> pkt_valid one cycle with pkt_data=32'h11223344, addr=9'h005, mem_type=0, rw=1.
REQ-039 Read header 12'h6FF -> pkt_valid with rw=0, mem_type=1, addr=9'h0FF, data=0, and no payload frames consumed.
REQ-040 Header 12'h805 -> err_valid with code 0; the next valid write packet is received correctly.
REQ-041 Write header plus 2 bytes, then silence for TIMEOUT_CYCLES -> err code 1, pkt_valid never rises.
REQ-042 pkt_ready=0 with a second header sent during HOLD -> err code 3; first packet intact; raising pkt_ready accepts it.
REQ-043 With UART_PKT_CHECKSUM_EN: bytes 01,02,04,08 plus check 0F -> pkt_valid; same bytes plus check 0E -> err code 2.
